// File: rtl/module_display_arbiter_pkg.sv
// Shared types and defaults for the display register-bank write arbiter.
`timescale 1ns/1ps
package pkg_display_arb;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } arb_state_t;

   localparam int DATA_W          = 32;
   localparam int HOLD_CYCLES_DEF = 10000;

endpackage

// File: rtl/module_hold_timer.sv
// Loadable down-counter that stops at zero; zero_o flags an expired count.
`timescale 1ns/1ps
module module_hold_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] value_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   // Saturates at zero so an idle timer never wraps.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= value_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/module_display_arbiter.sv
// Round-robin arbiter for the display register-bank write port, with a
// minimum display hold time after every write.
`timescale 1ns/1ps
module module_display_arbiter #(
   parameter int DATA_W      = pkg_display_arb::DATA_W,
   parameter int HOLD_CYCLES = pkg_display_arb::HOLD_CYCLES_DEF,
   parameter int CNT_W       = 20
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req0_i,
   input  logic [DATA_W-1:0] data0_i,
   input  logic              req1_i,
   input  logic [DATA_W-1:0] data1_i,
   output logic              gnt0_o,
   output logic              gnt1_o,
   output logic              write_en_o,
   output logic [DATA_W-1:0] data_o,
   output logic              owner_o,
   output logic              busy_o
);

   import pkg_display_arb::*;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   arb_state_t        state_q, state_d;
   logic              rr_q, rr_d;
   logic              winner;
   logic [DATA_W-1:0] data_d;
   logic              owner_d;
   logic              load;
   logic              hold_zero;

   module_hold_timer #(
      .CNT_W (CNT_W)
   ) u_hold_timer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (load),
      .value_i (HOLD_LOAD),
      .zero_o  (hold_zero)
   );

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      data_d  = data_o;
      owner_d = owner_o;
      load    = 1'b0;
      winner  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               // rr only breaks ties; a lone requester always wins.
               winner  = (req0_i && req1_i) ? rr_q : req1_i;
               data_d  = winner ? data1_i : data0_i;
               owner_d = winner;
               rr_d    = ~winner;
               state_d = WRITE;
            end
         end
         WRITE: begin
            load    = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (hold_zero) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         data_o     <= '0;
         owner_o    <= 1'b0;
         write_en_o <= 1'b0;
         gnt0_o     <= 1'b0;
         gnt1_o     <= 1'b0;
         busy_o     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         data_o     <= data_d;
         owner_o    <= owner_d;
         write_en_o <= (state_d == WRITE);
         gnt0_o     <= (state_d == WRITE) && !owner_d;
         gnt1_o     <= (state_d == WRITE) && owner_d;
         busy_o     <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_module_display_arbiter.sv
// Directed bench for module_display_arbiter with a short hold time.
`timescale 1ns/1ps
module tb_module_display_arbiter;

   localparam int DW = 32;
   localparam int HC = 4;
   localparam logic [DW-1:0] DZ = 32'h0000_0000;
   localparam logic [DW-1:0] DA = 32'h0000_1234;
   localparam logic [DW-1:0] DB = 32'hCAFE_0001;

   typedef struct {
      logic          rst_n;
      logic          req0;
      logic          req1;
      logic          we;
      logic          g0;
      logic          g1;
      logic [DW-1:0] dat;
      logic          own;
      logic          busy;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          req0_i = 1'b0;
   logic          req1_i = 1'b0;
   logic [DW-1:0] data0_i = DA;
   logic [DW-1:0] data1_i = DB;
   logic          gnt0_o, gnt1_o, write_en_o, owner_o, busy_o;
   logic [DW-1:0] data_o;

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   always #50 clk = ~clk;

   module_display_arbiter #(
      .DATA_W      (DW),
      .HOLD_CYCLES (HC),
      .CNT_W       (20)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n_i),
      .req0_i     (req0_i),
      .data0_i    (data0_i),
      .req1_i     (req1_i),
      .data1_i    (data1_i),
      .gnt0_o     (gnt0_o),
      .gnt1_o     (gnt1_o),
      .write_en_o (write_en_o),
      .data_o     (data_o),
      .owner_o    (owner_o),
      .busy_o     (busy_o)
   );

   task automatic add(input logic r, input logic q0, input logic q1,
                      input logic we, input logic g0, input logic g1,
                      input logic [DW-1:0] d, input logic own, input logic bsy);
      vec_t v;
      v.rst_n = r; v.req0 = q0; v.req1 = q1;
      v.we = we; v.g0 = g0; v.g1 = g1; v.dat = d; v.own = own; v.busy = bsy;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic ok, input string got, input string want);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %s, want %s", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int wr_cyc[$];
   int wr_own[$];
   logic saw_we;

   initial begin
      // Reset and idle
      add(0,0,0, 0,0,0,DZ,0,0); add(0,0,0, 0,0,0,DZ,0,0); add(0,0,0, 0,0,0,DZ,0,0);
      add(1,0,0, 0,0,0,DZ,0,0);
      // Single request: WRITE then four HOLD cycles, then IDLE
      add(1,1,0, 1,1,0,DA,0,1);
      add(1,0,0, 0,0,0,DA,0,1); add(1,0,0, 0,0,0,DA,0,1);
      add(1,0,0, 0,0,0,DA,0,1); add(1,0,0, 0,0,0,DA,0,1);
      add(1,0,0, 0,0,0,DA,0,0);
      // Request arriving two cycles into HOLD waits for IDLE
      add(1,1,0, 1,1,0,DA,0,1);
      add(1,0,0, 0,0,0,DA,0,1); add(1,0,0, 0,0,0,DA,0,1);
      add(1,0,1, 0,0,0,DA,0,1); add(1,0,1, 0,0,0,DA,0,1);
      add(1,0,1, 0,0,0,DA,0,0);
      add(1,0,1, 1,0,1,DB,1,1);
      add(1,0,0, 0,0,0,DB,1,1);
      // One-cycle request pulse inside HOLD is dropped
      add(1,1,0, 0,0,0,DB,1,1); add(1,0,0, 0,0,0,DB,1,1);
      add(1,0,0, 0,0,0,DB,1,1); add(1,0,0, 0,0,0,DB,1,0);
      add(1,0,0, 0,0,0,DB,1,0);
      // Both requesting after reset: 0, 1, 0
      add(0,0,0, 0,0,0,DZ,0,0);
      add(1,1,1, 1,1,0,DA,0,1);
      for (int i = 0; i < HC; i++) add(1,1,1, 0,0,0,DA,0,1);
      add(1,1,1, 0,0,0,DA,0,0);
      add(1,1,1, 1,0,1,DB,1,1);
      for (int i = 0; i < HC; i++) add(1,1,1, 0,0,0,DB,1,1);
      add(1,1,1, 0,0,0,DB,1,0);
      add(1,1,1, 1,1,0,DA,0,1);
      // Reset during WRITE clears rr: requester 0 wins again
      add(0,1,1, 0,0,0,DZ,0,0);
      add(1,1,1, 1,1,0,DA,0,1);
      add(0,0,0, 0,0,0,DZ,0,0);

      foreach (vecs[i]) begin
         rst_n_i = vecs[i].rst_n;
         req0_i  = vecs[i].req0;
         req1_i  = vecs[i].req1;
         step();
         check($sformatf("vec%0d", i),
               write_en_o === vecs[i].we && gnt0_o === vecs[i].g0 && gnt1_o === vecs[i].g1 &&
               data_o === vecs[i].dat && owner_o === vecs[i].own && busy_o === vecs[i].busy,
               $sformatf("we=%b g0=%b g1=%b d=%h own=%b busy=%b",
                         write_en_o, gnt0_o, gnt1_o, data_o, owner_o, busy_o),
               $sformatf("we=%b g0=%b g1=%b d=%h own=%b busy=%b",
                         vecs[i].we, vecs[i].g0, vecs[i].g1, vecs[i].dat, vecs[i].own, vecs[i].busy));
      end

      // Fifty idle cycles after reset: no strobe, never busy
      rst_n_i = 1'b0; req0_i = 1'b0; req1_i = 1'b0;
      repeat (3) step();
      rst_n_i = 1'b1;
      saw_we = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (write_en_o || busy_o || gnt0_o || gnt1_o) saw_we = 1'b1;
      end
      check("idle50", !saw_we, $sformatf("activity=%b", saw_we), "activity=0");

      // Asynchronous reset mid-WRITE takes effect before the next edge
      req0_i = 1'b1;
      step();
      req0_i = 1'b0;
      check("write_before_rst", write_en_o === 1'b1 && data_o === DA,
            $sformatf("we=%b d=%h", write_en_o, data_o), $sformatf("we=1 d=%h", DA));
      rst_n_i = 1'b0;
      #1;
      check("async_rst", write_en_o === 1'b0 && data_o === DZ && busy_o === 1'b0 && gnt0_o === 1'b0,
            $sformatf("we=%b d=%h busy=%b g0=%b", write_en_o, data_o, busy_o, gnt0_o),
            "we=0 d=00000000 busy=0 g0=0");
      step();
      rst_n_i = 1'b1;

      // Write spacing with both requests held continuously
      req0_i = 1'b1; req1_i = 1'b1;
      for (int c = 0; c < 40 && wr_cyc.size() < 3; c++) begin
         step();
         if (write_en_o) begin
            wr_cyc.push_back(c);
            wr_own.push_back(owner_o);
         end
      end
      req0_i = 1'b0; req1_i = 1'b0;
      if (wr_cyc.size() < 3) begin
         check("spacing_timeout", 1'b0, $sformatf("%0d writes", wr_cyc.size()), "3 writes");
      end else begin
         check("gap01", wr_cyc[1] - wr_cyc[0] == HC + 2,
               $sformatf("%0d", wr_cyc[1] - wr_cyc[0]), $sformatf("%0d", HC + 2));
         check("gap12", wr_cyc[2] - wr_cyc[1] == HC + 2,
               $sformatf("%0d", wr_cyc[2] - wr_cyc[1]), $sformatf("%0d", HC + 2));
         check("order", wr_own[0] == 0 && wr_own[1] == 1 && wr_own[2] == 0,
               $sformatf("%0d%0d%0d", wr_own[0], wr_own[1], wr_own[2]), "010");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/module_display_arbiter.md
Name: module_display_arbiter

Overview:
- Shares the single write port of the display register bank between two requesters, for example the SPI receive path and the local switch/debug path.
- Grants requesters in round-robin order and produces the write-enable pulse and data for the register bank.
- After each write, enforces a minimum hold time so the 7-segment multiplexer shows each value for at least HOLD_CYCLES clock cycles.
- Sits between the requesters and the register bank, in the 10 MHz clock domain.

Parameters:
- DATA_W, 32, width of each requester's data word and of the write data.
- HOLD_CYCLES, 10000, minimum number of cycles a written value is held before the next grant (1 ms at 10 MHz); legal range is 1 to 2^20-1.
- CNT_W, 20, width of the hold counter.

Ports:
- clk_i  in  1  system clock (10 MHz domain).
- rst_n_i  in  1  asynchronous active-low reset.
- req0_i  in  1  request from requester 0, level; held high until granted.
- data0_i  in  DATA_W  data from requester 0; must be stable while req0_i is high.
- req1_i  in  1  request from requester 1, level; held high until granted.
- data1_i  in  DATA_W  data from requester 1; must be stable while req1_i is high.
- gnt0_o  out  1  one-cycle grant pulse to requester 0.
- gnt1_o  out  1  one-cycle grant pulse to requester 1.
- write_en_o  out  1  one-cycle write strobe to the register bank.
- data_o  out  DATA_W  registered write data.
- owner_o  out  1  index of the requester that made the last write.
- busy_o  out  1  high in WRITE and HOLD states.

Behaviour:
- Reset (rst_n_i low, asynchronous): state goes to IDLE. All outputs are 0: gnt*, write_en_o, data_o, owner_o, busy_o. The round-robin pointer rr is 0, meaning requester 0 has priority. The hold counter is 0.
- All state is updated on the rising edge of clk_i. All outputs are registered.

State machine:
- IDLE:
  - If any request is high, pick the winner.
  - With a single request, that requester wins.
  - With both requests high, the winner is rr.
  - On the picking edge: data_o takes data of the winner, owner_o takes the winner index, rr takes the inverse of the winner, and the state goes to WRITE.
  - If no request is high, stay in IDLE.
- WRITE (exactly 1 cycle):
  - write_en_o and gnt of the winner are high in this same cycle.
  - busy_o is high.
  - The hold counter loads HOLD_CYCLES-1, then the state goes to HOLD.
- HOLD:
  - busy_o is high; write_en_o and both gnt outputs are 0.
  - The counter decrements each cycle.
  - When the counter equals 0, the state goes to IDLE on the next edge.
  - Requests arriving during HOLD are not granted; they wait.

Timing:
- Latency from a request sampled high in IDLE to its grant/write: 1 cycle. The request is seen at edge N; WRITE is active during cycle N+1.
- Minimum spacing between two consecutive write_en_o pulses is HOLD_CYCLES+2 cycles: 1 WRITE cycle, HOLD_CYCLES HOLD cycles, 1 IDLE arbitration cycle.
- With HOLD_CYCLES=1, HOLD lasts one cycle.

Boundary conditions:
- Both requests high continuously: grants alternate 0,1,0,1, starting with 0 after reset.
- A requester drops its request before being granted: it is not granted, and no error is raised.
- A requester keeps its request high after its grant: it is treated as a new request and competes again under round-robin.
- Reset asserted mid-WRITE or mid-HOLD: immediate return to the reset state. A pending write strobe is cancelled, and data_o clears to 0.
- The counter never wraps: it is loaded only in WRITE, and decrement happens only while it is nonzero.
- data_o holds its last value in HOLD and IDLE.

Decomposition:
- Shared package pkg_display_arb holds:
  - the typedef enum logic [1:0] arb_state_t {IDLE, WRITE, HOLD};
  - the localparam defaults DATA_W and HOLD_CYCLES_DEF.
- One sub-module, module_hold_timer: loadable down-counter with load_i, value_i, and zero_o outputs, reusable elsewhere in the design.
- The arbitration logic and state machine stay in the top arbiter module.

Test Plan:
- Reset behaviour: assert rst_n_i=0 for 3 cycles, then release with no requests -> all outputs 0, busy_o=0, no write_en_o for 50 cycles.
- Single request, HOLD_CYCLES=4: req0_i=1, data0_i=32'h0000_1234 -> one cycle later write_en_o=1, gnt0_o=1, data_o=32'h0000_1234, owner_o=0; then busy_o stays high for 4 more cycles.
- Simultaneous requests, HOLD_CYCLES=4: req0=req1=1 held, data1_i=32'hCAFE_0001 -> grants in the order 0,1,0 with write_en_o pulses exactly 6 cycles apart; data_o alternates accordingly.
- Request during hold: req1_i rises 2 cycles into HOLD -> gnt1_o only after HOLD finishes, with latency 1 cycle after IDLE; no write occurs inside HOLD.
- Reset mid-operation: rst_n_i low for 1 cycle during WRITE -> write_en_o and data_o are 0 immediately; the next grant after reset goes to requester 0 even if req1 is also high.
- Dropped request: req1_i pulsed for 1 cycle during HOLD, then low -> no gnt1_o, and the state returns to IDLE with busy_o=0.
